// File: rtl/hw2_seq_monitor.sv
`default_nettype none
// =============================================================================
//  Module   : hw2_seq_monitor
//  Purpose  : Passive checker for the HW2 step sequencer. A reference model of
//             the step sequence is compared against the observed status.
//  Revision : 1.0  initial release
// =============================================================================
module hw2_seq_monitor #(
    parameter int ERR_W = 8,
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             pause,
    input  logic             goto_third,
    input  logic [2:0]       out1,
    input  logic [2:0]       out2,
    input  logic             odd,
    input  logic             even,
    input  logic             terminal,
    input  logic             clear,
    output logic             synced,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count,
    output logic [2:0]       first_err_exp
);

    localparam logic [2:0]       c_LAST_STEP  = 3'd5;
    localparam logic [2:0]       c_THIRD_STEP = 3'd2;
    localparam logic [ERR_W-1:0] c_ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [LAP_W-1:0] c_LAP_MAX    = {LAP_W{1'b1}};

    typedef enum logic [0:0] {
        ST_UNSYNCED = 1'b0,
        ST_SYNCED   = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_step;
    logic [2:0]       w_step_nxt;
    logic [2:0]       w_adv_step;
    logic [2:0]       w_exp_out2;
    logic             w_exp_term;
    logic             w_mismatch;
    logic             w_hit;
    logic             w_lap;

    logic             r_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_count;
    logic [LAP_W-1:0] r_lap_count;
    logic [2:0]       r_first_err_exp;

    logic             w_err_sticky_nxt;
    logic [ERR_W-1:0] w_err_count_nxt;
    logic [LAP_W-1:0] w_lap_count_nxt;
    logic [2:0]       w_first_err_nxt;

    // Expected status is derived purely from the model step, never from out1,
    // so an illegal out1 (6..7) can never match.
    assign w_exp_out2 = c_LAST_STEP - r_step;
    assign w_exp_term = (r_step == c_LAST_STEP);
    assign w_mismatch = (out1 != r_step)
                      | (out2 != w_exp_out2)
                      | (odd != r_step[0])
                      | (even != ~r_step[0])
                      | (terminal != w_exp_term);

    always_comb begin
        w_adv_step = r_step;
        if (restart) begin
            w_adv_step = 3'd0;
        end else if (goto_third) begin
            w_adv_step = c_THIRD_STEP;
        end else if (pause) begin
            w_adv_step = r_step;
        end else if (r_step == c_LAST_STEP) begin
            w_adv_step = 3'd0;
        end else begin
            w_adv_step = r_step + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_UNSYNCED;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_hit       = 1'b0;
        w_lap       = 1'b0;
        case (r_state)
            ST_UNSYNCED: begin
                if (restart) begin
                    w_state_nxt = ST_SYNCED;
                    w_step_nxt  = 3'd0;
                end
            end
            ST_SYNCED: begin
                w_hit      = w_mismatch;
                w_step_nxt = w_adv_step;
                w_lap      = !restart && !goto_third && !pause
                             && (r_step == c_LAST_STEP);
            end
            default: begin
                w_state_nxt = ST_UNSYNCED;
                w_step_nxt  = 3'd0;
            end
        endcase
    end

    // A mismatch in the same cycle as clear takes precedence over the clear.
    always_comb begin
        w_err_sticky_nxt = r_err_sticky;
        w_err_count_nxt  = r_err_count;
        w_lap_count_nxt  = r_lap_count;
        w_first_err_nxt  = r_first_err_exp;

        if (clear) begin
            w_err_sticky_nxt = 1'b0;
            w_err_count_nxt  = '0;
            w_lap_count_nxt  = '0;
            w_first_err_nxt  = 3'd0;
        end

        if (w_hit) begin
            w_err_sticky_nxt = 1'b1;
            if (clear) begin
                w_err_count_nxt = {{(ERR_W-1){1'b0}}, 1'b1};
            end else if (r_err_count != c_ERR_MAX) begin
                w_err_count_nxt = r_err_count + 1'b1;
            end
            if (!r_err_sticky || clear) begin
                w_first_err_nxt = r_step;
            end
        end

        if (w_lap) begin
            if (clear) begin
                w_lap_count_nxt = {{(LAP_W-1){1'b0}}, 1'b1};
            end else if (r_lap_count != c_LAP_MAX) begin
                w_lap_count_nxt = r_lap_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err           <= 1'b0;
            r_err_sticky    <= 1'b0;
            r_err_count     <= '0;
            r_lap_count     <= '0;
            r_first_err_exp <= 3'd0;
        end else begin
            r_err           <= w_hit;
            r_err_sticky    <= w_err_sticky_nxt;
            r_err_count     <= w_err_count_nxt;
            r_lap_count     <= w_lap_count_nxt;
            r_first_err_exp <= w_first_err_nxt;
        end
    end

    assign synced        = (r_state == ST_SYNCED);
    assign err           = r_err;
    assign err_sticky    = r_err_sticky;
    assign err_count     = r_err_count;
    assign lap_count     = r_lap_count;
    assign first_err_exp = r_first_err_exp;

endmodule
`default_nettype wire

// File: tb/tb_hw2_seq_monitor.sv
`default_nettype none
// =============================================================================
//  Module   : tb_hw2_seq_monitor
//  Purpose  : Scoreboard bench for hw2_seq_monitor driven by a behavioural
//             sequencer with selectable status corruption.
//  Revision : 1.0  initial release
// =============================================================================
module tb_hw2_seq_monitor;

    logic       clk;
    logic       reset_n;
    logic       restart, pause, goto_third, clear;
    logic [2:0] out1, out2;
    logic       odd, even, terminal;
    logic       synced, err, err_sticky;
    logic [7:0] err_count, lap_count;
    logic [2:0] first_err_exp;

    hw2_seq_monitor #(.ERR_W(8), .LAP_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .restart      (restart),
        .pause        (pause),
        .goto_third   (goto_third),
        .out1         (out1),
        .out2         (out2),
        .odd          (odd),
        .even         (even),
        .terminal     (terminal),
        .clear        (clear),
        .synced       (synced),
        .err          (err),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .lap_count    (lap_count),
        .first_err_exp(first_err_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       synced;
        logic       err;
        logic       sticky;
        logic [7:0] cnt;
        logic [7:0] lap;
        logic [2:0] fe;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural sequencer plus the expected monitor state
    logic [2:0] seq_step = 3'd0;
    logic       m_synced = 1'b0;
    logic [2:0] m_step   = 3'd0;
    logic       m_err    = 1'b0;
    logic       m_sticky = 1'b0;
    logic [7:0] m_cnt    = 8'd0;
    logic [7:0] m_lap    = 8'd0;
    logic [2:0] m_fe     = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] next_step(input logic [2:0] s, input logic r,
                                             input logic p, input logic g);
        if (r)      return 3'd0;
        if (g)      return 3'd2;
        if (p)      return s;
        if (s == 3'd5) return 3'd0;
        return s + 3'd1;
    endfunction

    // corrupt: 0 none, 1 wrong out2, 2 out1 forced to 7, 3 odd flipped
    task automatic cycle(input logic r, input logic p, input logic g,
                         input int corrupt, input logic clr);
        exp_t e;
        logic hit, lapev;
        @(negedge clk);
        restart    = r;
        pause      = p;
        goto_third = g;
        clear      = clr;
        out1       = seq_step;
        out2       = 3'd5 - seq_step;
        odd        = seq_step[0];
        even       = ~seq_step[0];
        terminal   = (seq_step == 3'd5);
        case (corrupt)
            1: out2 = out2 ^ 3'd1;
            2: out1 = 3'd7;
            3: odd  = ~odd;
            default: ;
        endcase

        hit   = m_synced && (corrupt != 0);
        lapev = 1'b0;
        if (hit && (!m_sticky || clr)) m_fe = m_step;
        else if (clr)                  m_fe = 3'd0;
        if (m_synced) begin
            lapev  = !r && !g && !p && (m_step == 3'd5);
            m_step = next_step(m_step, r, p, g);
        end else if (r) begin
            m_synced = 1'b1;
            m_step   = 3'd0;
        end
        m_err    = hit;
        m_sticky = hit ? 1'b1 : (clr ? 1'b0 : m_sticky);
        if (clr)                        m_cnt = hit ? 8'd1 : 8'd0;
        else if (hit && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (clr)                          m_lap = lapev ? 8'd1 : 8'd0;
        else if (lapev && m_lap != 8'hFF) m_lap = m_lap + 8'd1;
        e = '{synced: m_synced, err: m_err, sticky: m_sticky,
              cnt: m_cnt, lap: m_lap, fe: m_fe};
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        seq_step = next_step(seq_step, r, p, g);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("synced",     synced,        e.synced);
            check("err",        err,           e.err);
            check("err_sticky", err_sticky,    e.sticky);
            check("err_count",  err_count,     e.cnt);
            check("lap_count",  lap_count,     e.lap);
            check("first_err",  first_err_exp, e.fe);
        end
    endtask

    task automatic run_to_step(input logic [2:0] target);
        int guard;
        guard = 0;
        while (seq_step != target && guard < 10) begin
            cycle(0, 0, 0, 0, 0);
            guard++;
        end
        if (seq_step != target) check("run_to_step_timeout", seq_step, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_synced"}, synced,        0);
        check({tag, "_err"},    err,           0);
        check({tag, "_sticky"}, err_sticky,    0);
        check({tag, "_cnt"},    err_count,     0);
        check({tag, "_lap"},    lap_count,     0);
        check({tag, "_fe"},     first_err_exp, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        {restart, pause, goto_third, clear} = 4'b0;
        out1 = 3'd0; out2 = 3'd5; odd = 1'b0; even = 1'b1; terminal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Sync, then free run two full laps
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0);
        check("lap_after_12", lap_count, 2);

        // Alternating pause
        for (int i = 0; i < 8; i++) cycle(0, (i % 2) == 0, 0, 0, 0);

        // Restart priority over pause/goto_third, then goto_third alone
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Single error at step 3, later error at step 4
        run_to_step(3'd3);
        cycle(0, 0, 0, 1, 0);
        check("first_err_step3", first_err_exp, 3);
        cycle(0, 0, 0, 3, 0);
        check("first_err_kept", first_err_exp, 3);
        check("err_count_two", err_count, 2);

        // Saturation of err_count
        for (int i = 0; i < 300; i++) cycle(i[0], 0, 0, (i % 2) + 1, 0);
        check("err_count_sat", err_count, 255);
        cycle(0, 0, 0, 0, 1);
        check("clear_cnt", err_count, 0);
        check("clear_synced", synced, 1);

        // Mismatch wins over a simultaneous clear
        cycle(0, 0, 0, 2, 1);
        check("clr_hit_cnt", err_count, 1);
        cycle(0, 0, 0, 0, 1);

        // Reset mid-lap at step 4 with non-zero outputs present
        run_to_step(3'd3);
        cycle(0, 0, 0, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midlap");
        m_synced = 1'b0; m_step = 3'd0; m_err = 1'b0; m_sticky = 1'b0;
        m_cnt = 8'd0; m_lap = 8'd0; m_fe = 3'd0;
        seq_step = 3'd0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 2, 0);
        check("post_reset_unsynced", synced, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
